// File: rtl/tm_buffer_drain_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tm_buffer_drain_if : tile-buffer read port plus output word stream
// Rev 1.0
// ----------------------------------------------------------------------------
`ifndef Tm
`define Tm 4
`endif
`ifndef FEATURE_WIDTH
`define FEATURE_WIDTH 16
`endif

interface tm_buffer_drain_if #(
  parameter int Tm            = `Tm,
  parameter int FEATURE_WIDTH = `FEATURE_WIDTH,
  parameter int ADDR_WIDTH    = 8
);
  logic                        buf_rd_en;
  logic [ADDR_WIDTH-1:0]       buf_rd_addr;
  logic [Tm*FEATURE_WIDTH-1:0] buf_rd_data;
  logic                        out_valid;
  logic [Tm*FEATURE_WIDTH-1:0] out_data;
  logic                        out_ready;

  modport master (
    output buf_rd_en, buf_rd_addr, out_valid, out_data,
    input  buf_rd_data, out_ready
  );

  modport slave (
    input  buf_rd_en, buf_rd_addr, out_valid, out_data,
    output buf_rd_data, out_ready
  );
endinterface

`default_nettype wire

// File: rtl/tm_buffer_drain.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tm_buffer_drain : lock-step reader of Tm tile buffers into a 4-deep stream
// FIFO. Optional ReLU on the FIFO write side via DRAIN_RELU_EN.  Rev 1.0
// ----------------------------------------------------------------------------
`ifndef Tm
`define Tm 4
`endif
`ifndef FEATURE_WIDTH
`define FEATURE_WIDTH 16
`endif

module tm_buffer_drain #(
  parameter int Tm            = `Tm,
  parameter int FEATURE_WIDTH = `FEATURE_WIDTH,
  parameter int ADDR_WIDTH    = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH:0]   depth,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH:0]   word_count,
  tm_buffer_drain_if.master     bus
);

  localparam int C_WORD_W = Tm * FEATURE_WIDTH;

  localparam logic [1:0] C_IDLE  = 2'd0;
  localparam logic [1:0] C_READ  = 2'd1;
  localparam logic [1:0] C_FLUSH = 2'd2;
  localparam logic [1:0] C_DONE  = 2'd3;

  logic [1:0]            state_q, state_d;
  logic [ADDR_WIDTH:0]   depth_q, depth_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  inflight_q, inflight_d;
  logic [ADDR_WIDTH:0]   wc_q, wc_d;
  logic [1:0]            wr_ptr_q, wr_ptr_d;
  logic [1:0]            rd_ptr_q, rd_ptr_d;
  logic [2:0]            cnt_q, cnt_d;
  logic [C_WORD_W-1:0]   mem_q [4];
  logic [C_WORD_W-1:0]   mem_d [4];

  logic                  w_issue;
  logic                  w_push;
  logic                  w_pop;
  logic [ADDR_WIDTH:0]   w_last_idx;
  logic [C_WORD_W-1:0]   w_push_data;

  function automatic logic [C_WORD_W-1:0] lane_filter(input logic [C_WORD_W-1:0] w);
    lane_filter = w;
`ifdef DRAIN_RELU_EN
    for (int i = 0; i < Tm; i++) begin
      if (w[i*FEATURE_WIDTH + FEATURE_WIDTH - 1]) begin
        lane_filter[i*FEATURE_WIDTH +: FEATURE_WIDTH] = '0;
      end
    end
`endif
  endfunction

  // Credit check ignores a same-cycle pop so that at most 3 words are ever owed to the FIFO.
  always_comb begin
    w_issue     = (state_q == C_READ) &&
                  (({1'b0, cnt_q} + {3'b000, inflight_q}) <= 4'd2);
    w_push      = inflight_q;
    w_pop       = (cnt_q != 3'd0) && bus.out_ready;
    w_last_idx  = depth_q - 1'b1;
    w_push_data = lane_filter(bus.buf_rd_data);
  end

  always_comb begin
    state_d    = state_q;
    depth_d    = depth_q;
    addr_d     = w_issue ? addr_q + 1'b1 : addr_q;
    inflight_d = w_issue;
    wc_d       = wc_q + (ADDR_WIDTH+1)'(w_pop);
    wr_ptr_d   = wr_ptr_q + 2'(w_push);
    rd_ptr_d   = rd_ptr_q + 2'(w_pop);
    cnt_d      = cnt_q + 3'(w_push) - 3'(w_pop);
    for (int i = 0; i < 4; i++) begin
      mem_d[i] = mem_q[i];
    end
    if (w_push) begin
      mem_d[wr_ptr_q] = w_push_data;
    end

    case (state_q)
      C_IDLE: begin
        if (start) begin
          depth_d = depth;
          addr_d  = '0;
          wc_d    = '0;
          state_d = (depth == '0) ? C_DONE : C_READ;
        end
      end
      C_READ: begin
        if (w_issue && (addr_q == w_last_idx[ADDR_WIDTH-1:0])) begin
          state_d = C_FLUSH;
        end
      end
      // Look at next-cycle occupancy and count so done follows the final handshake directly.
      C_FLUSH: begin
        if (!inflight_q && (cnt_d == 3'd0) && (wc_d == depth_q)) begin
          state_d = C_DONE;
        end
      end
      default: begin
        state_d = C_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= C_IDLE;
      depth_q    <= '0;
      addr_q     <= '0;
      inflight_q <= 1'b0;
      wc_q       <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      for (int i = 0; i < 4; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      depth_q    <= depth_d;
      addr_q     <= addr_d;
      inflight_q <= inflight_d;
      wc_q       <= wc_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      for (int i = 0; i < 4; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  always_comb begin
    busy            = (state_q == C_READ) || (state_q == C_FLUSH);
    done            = (state_q == C_DONE);
    word_count      = wc_q;
    bus.buf_rd_en   = w_issue;
    bus.buf_rd_addr = addr_q;
    bus.out_valid   = (cnt_q != 3'd0);
    bus.out_data    = (cnt_q != 3'd0) ? mem_q[rd_ptr_q] : '0;
  end

endmodule

`default_nettype wire

// File: tb/tb_tm_buffer_drain.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_tm_buffer_drain : directed scoreboard bench for tm_buffer_drain
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_tm_buffer_drain;

  localparam int TM = 4;
  localparam int FW = 16;
  localparam int AW = 8;
  localparam int W  = TM * FW;

  typedef struct {
    logic [W-1:0] w;
    int           cyc;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW:0]   depth;
  logic          busy;
  logic          done;
  logic [AW:0]   word_count;

  tm_buffer_drain_if #(.Tm(TM), .FEATURE_WIDTH(FW), .ADDR_WIDTH(AW)) bus ();

  tm_buffer_drain #(.Tm(TM), .FEATURE_WIDTH(FW), .ADDR_WIDTH(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .depth      (depth),
    .busy       (busy),
    .done       (done),
    .word_count (word_count),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  logic [W-1:0] mem [256];
  exp_t         exp_q [$];
  int           cyc = 0;
  int           t0 = 0;
  int           total = 0;
  int           bad = 0;
  int           rd_cnt = 0;
  int           done_cnt = 0;
  int           done_rel = -1;
  int           valid_cnt = 0;
  int           addr_err = 0;
  int           next_addr = 0;
  int           rd_base, done_base, valid_base, err_base;

  always @(posedge clk) cyc <= cyc + 1;

  // Buffer model: registered read, data one cycle after the enable.
  always @(posedge clk) begin
    if (bus.buf_rd_en) bus.buf_rd_data <= mem[bus.buf_rd_addr];
  end

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] pat(input int a);
    logic [W-1:0] v;
    for (int i = 0; i < TM; i++) v[i*FW +: FW] = 16'(16*a + i);
    return v;
  endfunction

  // Monitor: scoreboard pops, read/done/valid bookkeeping.
  always @(negedge clk) begin
    if (rst) begin
      if (bus.out_valid) valid_cnt++;
      if (!busy) next_addr = 0;
      if (bus.buf_rd_en) begin
        rd_cnt++;
        if (int'(bus.buf_rd_addr) != next_addr) addr_err++;
        next_addr = (int'(bus.buf_rd_addr) + 1) % 256;
      end
      if (done) begin
        done_cnt++;
        done_rel = cyc - t0;
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL extra_word: got %0h expected none", bus.out_data);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("word_data", bus.out_data, e.w);
          if (e.cyc >= 0) check("word_cycle", W'(cyc - t0), W'(e.cyc));
        end
      end
    end
  end

  task automatic do_start(input logic [AW:0] d);
    @(posedge clk);
    #1;
    rd_base    = rd_cnt;
    done_base  = done_cnt;
    valid_base = valid_cnt;
    err_base   = addr_err;
    start = 1'b1;
    depth = d;
    @(posedge clk);
    #1;
    t0    = cyc - 1;
    start = 1'b0;
  endtask

  task automatic wait_rel(input int k);
    while (1) begin
      @(posedge clk);
      #1;
      if (cyc - t0 >= k) break;
    end
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (done_cnt == done_base && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (done_cnt == done_base) begin
      total++;
      bad++;
      $display("FAIL done_timeout: got no done expected done within %0d cycles", budget);
    end
    @(negedge clk);
  endtask

  initial begin
    logic [W-1:0] relu_in;
    logic [W-1:0] relu_exp;
    rst = 1'b0;
    start = 1'b0;
    depth = '0;
    bus.out_ready = 1'b0;
    for (int a = 0; a < 256; a++) mem[a] = pat(a);

    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", W'(busy), '0);
    check("rst_done", W'(done), '0);
    check("rst_rd_en", W'(bus.buf_rd_en), '0);
    check("rst_rd_addr", W'(bus.buf_rd_addr), '0);
    check("rst_valid", W'(bus.out_valid), '0);
    check("rst_data", bus.out_data, '0);
    check("rst_wc", W'(word_count), '0);
    #3 rst = 1'b1;

    // Throughput, depth 4
    bus.out_ready = 1'b1;
    for (int a = 0; a < 4; a++) exp_q.push_back('{pat(a), 3 + a});
    do_start(9'd4);
    check("tp_busy", W'(busy), 1);
    wait_done(50);
    check("tp_done_cycle", W'(done_rel), 7);
    check("tp_wc", W'(word_count), 4);
    check("tp_reads", W'(rd_cnt - rd_base), 4);
    check("tp_sb_empty", W'(exp_q.size()), 0);

    // Backpressure, depth 6
    bus.out_ready = 1'b0;
    for (int a = 0; a < 6; a++) exp_q.push_back('{pat(a), -1});
    do_start(9'd6);
    wait_rel(4);
    check("bp_valid", W'(bus.out_valid), 1);
    check("bp_data_c4", bus.out_data, pat(0));
    wait_rel(10);
    check("bp_reads", W'(rd_cnt - rd_base), 3);
    check("bp_data_c10", bus.out_data, pat(0));
    wait_rel(11);
    bus.out_ready = 1'b1;
    wait_done(60);
    check("bp_done_cycle", W'(done_rel), 17);
    check("bp_wc", W'(word_count), 6);
    check("bp_addr_order", W'(addr_err - err_base), 0);
    check("bp_sb_empty", W'(exp_q.size()), 0);

    // depth 0
    do_start(9'd0);
    wait_done(10);
    check("d0_done_cycle", W'(done_rel), 1);
    check("d0_reads", W'(rd_cnt - rd_base), 0);
    check("d0_valid", W'(valid_cnt - valid_base), 0);
    check("d0_wc", W'(word_count), 0);

    // depth 256: full address space once
    for (int a = 0; a < 256; a++) exp_q.push_back('{pat(a), 3 + a});
    do_start(9'd256);
    wait_done(400);
    check("full_done_cycle", W'(done_rel), 259);
    check("full_reads", W'(rd_cnt - rd_base), 256);
    check("full_addr_order", W'(addr_err - err_base), 0);
    check("full_wc", W'(word_count), 256);
    check("full_sb_empty", W'(exp_q.size()), 0);

    // Ignored starts: mid-drain and in the DONE cycle
    for (int a = 0; a < 5; a++) exp_q.push_back('{pat(a), 3 + a});
    do_start(9'd5);
    wait_rel(2);
    start = 1'b1;
    depth = 9'd3;
    wait_rel(3);
    start = 1'b0;
    wait_rel(8);
    check("ign_done_c8", W'(done), 1);
    start = 1'b1;
    depth = 9'd5;
    wait_rel(9);
    start = 1'b0;
    wait_rel(13);
    check("ign_done_count", W'(done_cnt - done_base), 1);
    check("ign_busy", W'(busy), 0);
    check("ign_wc", W'(word_count), 5);
    check("ign_reads", W'(rd_cnt - rd_base), 5);
    check("ign_sb_empty", W'(exp_q.size()), 0);

    // Reset mid-drain after three words
    for (int a = 0; a < 3; a++) exp_q.push_back('{pat(a), 3 + a});
    do_start(9'd8);
    wait_rel(6);
    #1 rst = 1'b0;
    #1;
    check("mr_busy", W'(busy), 0);
    check("mr_rd_en", W'(bus.buf_rd_en), 0);
    check("mr_valid", W'(bus.out_valid), 0);
    check("mr_data", bus.out_data, '0);
    check("mr_wc", W'(word_count), 0);
    check("mr_sb_empty", W'(exp_q.size()), 0);
    @(negedge clk);
    rst = 1'b1;
    exp_q.push_back('{pat(0), 3});
    exp_q.push_back('{pat(1), 4});
    do_start(9'd2);
    wait_done(20);
    check("mr2_done_cycle", W'(done_rel), 5);
    check("mr2_wc", W'(word_count), 2);
    check("mr2_sb_empty", W'(exp_q.size()), 0);

    // Lane clamp: lanes {-3, 5, -32768, 0}
    relu_in = {16'hFFFD, 16'h0005, 16'h8000, 16'h0000};
`ifdef DRAIN_RELU_EN
    relu_exp = {16'h0000, 16'h0005, 16'h0000, 16'h0000};
`else
    relu_exp = relu_in;
`endif
    mem[0] = relu_in;
    exp_q.push_back('{relu_exp, 3});
    do_start(9'd1);
    wait_done(20);
    check("relu_done_cycle", W'(done_rel), 4);
    check("relu_sb_empty", W'(exp_q.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
